alu_regfile: RTL and testbench
==============================

// Module: alu_regfile
// PURPOSE
//   Datapath core: a 64-entry x 32-bit register file (1 read port, 1 write port) plus a
//   combinational 32-bit ALU with a 5-bit opcode. The ALU and register file are independent;
//   the parent datapath wires the ALU result into the register-file write data. A typical use is
//   a sequence generator: a = R[n-2], b = R[n-1], op = ADD, result written to R[n].
// PARAMETERS
//   DW     32  data width of the ALU and the register file
//   AW     6   register-file address width (depth = 2**AW = 64)
//   OPW    5   ALU opcode width
// PORTS
//   clk     in   1    clock; every register-file write happens on its rising edge
//   rst     in   1    asynchronous, active-high reset; clears all register-file entries
//   re      in   1    read enable
//   raddr   in   AW   read address
//   rdata   out  DW   read data
//   waddr   in   AW   write address
//   wdata   in   DW   write data
//   we      in   1    write enable
//   alu_a   in   DW   ALU operand A
//   alu_b   in   DW   ALU operand B
//   alu_op  in   OPW  ALU opcode
//   alu_y   out  DW   ALU result
//   alu_zero out 1    1 when alu_y == 0
//   alu_ovf  out 1    signed overflow; driven only by ADD and SUB, 0 for every other opcode
// BEHAVIOUR
//   Reset: while rst = 1, all 64 entries are 0. This takes effect immediately, with no clock needed.
//   Reset outputs: rdata = 0. ALU outputs are purely combinational and do not depend on reset.
//   Write: on posedge clk with rst = 0 and we = 1, mem[waddr] <= wdata.
//     - All 64 entries are writable; there is no hardwired-zero register.
//   Read: combinational. rdata = re ? mem[raddr] : 0.
//     - There is no write-to-read bypass. A read of the address being written returns the old
//       value until the clock edge, and the new value after it.
//   Reset asserted mid-operation: it overrides a same-cycle write, so that write is lost.
//   ALU: combinational with zero latency. Results wrap modulo 2**32.
//     00 AND   a & b
//     01 ADD   a + b, with ovf = (a[31] == b[31]) && (y[31] != a[31])
//     02 SUB   a - b, with ovf = (a[31] != b[31]) && (y[31] != a[31])
//     03 OR    a | b
//     04 XOR   a ^ b
//     05 NOR   ~(a | b)
//     06 SLT   {31'b0, $signed(a) < $signed(b)}
//     07 SLTU  {31'b0, a < b}
//     08 SLL   b << a[4:0]
//     09 SRL   b >> a[4:0]
//     0A SRA   $signed(b) >>> a[4:0]
//     0B LUI   {b[15:0], 16'h0}
//     all other opcodes: y = 0 and ovf = 0
// STRUCTURE
//   Shared package (alu_pkg): opcode localparams (OP_AND .. OP_LUI), plus DW, AW and OPW defaults.
//   One sub-module, alu (combinational, case on alu_op). The register file is inline in
//   alu_regfile and uses an async-reset flop array.
// TESTING
//   1. Reset clear: write 0xDEADBEEF to R5, then pulse rst with no clock running
//      -> reading R5 with re = 1 returns 0.
//   2. Write/read: we = 1, waddr = 63, wdata = 0x12345678, then one clock edge
//      -> rdata(raddr = 63) = 0x12345678. With re = 0 -> rdata = 0.
//   3. Read during write: raddr = waddr = 7 holding 0x1, wdata = 0x2
//      -> rdata = 0x1 before the edge and 0x2 after it.
//   4. Fibonacci chain: R0 = 0 and R1 = 1; for n = 2..63, set a = R[n-2], b = R[n-1], op = 01 and
//      write to R[n] -> R10 = 55, R47 = 0xB11924E1, R48 wraps to 0x1E8D0A40.
//   5. ALU edge cases:
//      - ADD 0x7FFFFFFF + 1 -> y = 0x80000000, ovf = 1
//      - SUB 0 - 0 -> y = 0, zero = 1
//      - SLT 0xFFFFFFFF vs 1 -> 1, and SLTU with the same operands -> 0
//      - SRA with b = 0x80000000, a = 4 -> 0xF8000000
//      - opcode 1F -> y = 0
//   6. Reset mid-write: assert rst in the same cycle as we = 1 to R3 -> R3 reads 0 after rst drops.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths and ALU opcode encodings for the alu_regfile datapath slice.
package alu_pkg;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 6;
    localparam int unsigned OPW = 5;

    localparam logic [OPW-1:0] OP_AND  = 5'h00;
    localparam logic [OPW-1:0] OP_ADD  = 5'h01;
    localparam logic [OPW-1:0] OP_SUB  = 5'h02;
    localparam logic [OPW-1:0] OP_OR   = 5'h03;
    localparam logic [OPW-1:0] OP_XOR  = 5'h04;
    localparam logic [OPW-1:0] OP_NOR  = 5'h05;
    localparam logic [OPW-1:0] OP_SLT  = 5'h06;
    localparam logic [OPW-1:0] OP_SLTU = 5'h07;
    localparam logic [OPW-1:0] OP_SLL  = 5'h08;
    localparam logic [OPW-1:0] OP_SRL  = 5'h09;
    localparam logic [OPW-1:0] OP_SRA  = 5'h0A;
    localparam logic [OPW-1:0] OP_LUI  = 5'h0B;

endpackage

// File: rtl/alu.sv
// Combinational ALU: result, zero flag and signed overflow (ADD/SUB only).
module alu
    import alu_pkg::*;
(
    input  logic [alu_pkg::DW-1:0]  a,
    input  logic [alu_pkg::DW-1:0]  b,
    input  logic [alu_pkg::OPW-1:0] op,
    output logic [alu_pkg::DW-1:0]  y,
    output logic                    zero,
    output logic                    ovf
);

    localparam int unsigned SW = $clog2(alu_pkg::DW);

    logic [SW-1:0] shamt;
    assign shamt = a[SW-1:0];

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_ADD: begin
                y   = a + b;
                ovf = (a[DW-1] == b[DW-1]) && (y[DW-1] != a[DW-1]);
            end
            OP_SUB: begin
                y   = a - b;
                ovf = (a[DW-1] != b[DW-1]) && (y[DW-1] != a[DW-1]);
            end
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            OP_SLT:  y = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: y = {{(DW-1){1'b0}}, a < b};
            // Shifts take the amount from a and shift b.
            OP_SLL:  y = b << shamt;
            OP_SRL:  y = b >> shamt;
            OP_SRA:  y = $signed(b) >>> shamt;
            OP_LUI:  y = {b[DW/2-1:0], {(DW/2){1'b0}}};
            default: ;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/alu_regfile.sv
// Datapath core: 2**AW x DW register file (1R/1W, async clear) plus an independent ALU.
module alu_regfile
    import alu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    re,
    input  logic [alu_pkg::AW-1:0]  raddr,
    output logic [alu_pkg::DW-1:0]  rdata,
    input  logic [alu_pkg::AW-1:0]  waddr,
    input  logic [alu_pkg::DW-1:0]  wdata,
    input  logic                    we,
    input  logic [alu_pkg::DW-1:0]  alu_a,
    input  logic [alu_pkg::DW-1:0]  alu_b,
    input  logic [alu_pkg::OPW-1:0] alu_op,
    output logic [alu_pkg::DW-1:0]  alu_y,
    output logic                    alu_zero,
    output logic                    alu_ovf
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];

    // Reset wins over a same-cycle write; no read bypass of the pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = re ? mem_q[raddr] : '0;

    alu u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .op   (alu_op),
        .y    (alu_y),
        .zero (alu_zero),
        .ovf  (alu_ovf)
    );

endmodule

// File: tb/tb_alu_regfile.sv
// Self-checking bench for alu_regfile: reference model, per-cycle compare, directed vectors.
module tb_alu_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        re, we, chain;
    logic [5:0]  raddr, waddr;
    logic [31:0] wdata_tb, wdata, alu_a, alu_b, rdata, alu_y;
    logic [4:0]  alu_op;
    logic        alu_zero, alu_ovf;

    int          total = 0;
    int          bad = 0;
    bit          chk_en = 1'b0;
    logic [31:0] model [64];
    logic [31:0] fib [64];

    always #5 clk = ~clk;

    // Chain mode models the parent datapath feeding the ALU result into the write port.
    assign wdata = chain ? alu_y : wdata_tb;

    alu_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .re       (re),
        .raddr    (raddr),
        .rdata    (rdata),
        .waddr    (waddr),
        .wdata    (wdata),
        .we       (we),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_y    (alu_y),
        .alu_zero (alu_zero),
        .alu_ovf  (alu_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void alu_ref(input logic [4:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] y,
                                    output logic z, output logic o);
        longint r;
        int unsigned sh;
        sh = a % 32;
        y  = 32'h0;
        o  = 1'b0;
        case (op)
            5'h00: y = a & b;
            5'h01: begin
                r = longint'(int'(a)) + longint'(int'(b));
                y = r[31:0];
                o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            5'h02: begin
                r = longint'(int'(a)) - longint'(int'(b));
                y = r[31:0];
                o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            5'h03: y = a | b;
            5'h04: y = a ^ b;
            5'h05: y = ~(a | b);
            5'h06: y = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            5'h07: y = (a < b) ? 32'd1 : 32'd0;
            5'h08: begin
                r = longint'(b) * (longint'(1) << sh);
                y = r[31:0];
            end
            5'h09: begin
                r = longint'(b) / (longint'(1) << sh);
                y = r[31:0];
            end
            5'h0A: begin
                r = longint'(int'(b)) >>> sh;
                y = r[31:0];
            end
            5'h0B: y = (b & 32'h0000FFFF) * 32'h00010000;
            default: y = 32'h0;
        endcase
        z = (y == 32'h0);
    endfunction

    // Reference register file: async clear, write on rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) model[i] = 32'h0;
        end else if (we) begin
            model[waddr] = wdata;
        end
    end

    always @(negedge clk) begin
        logic [31:0] ey;
        logic        ez, eo;
        if (chk_en) begin
            alu_ref(alu_op, alu_a, alu_b, ey, ez, eo);
            check("cyc_rdata", rdata, re ? model[raddr] : 32'h0);
            check("cyc_alu_y", alu_y, ey);
            check("cyc_alu_zero", {31'b0, alu_zero}, {31'b0, ez});
            check("cyc_alu_ovf", {31'b0, alu_ovf}, {31'b0, eo});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        z;
        logic        o;
    } vec_t;

    vec_t vecs [15];

    initial begin
        vecs[0]  = '{5'h01, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        vecs[1]  = '{5'h02, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
        vecs[2]  = '{5'h06, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
        vecs[3]  = '{5'h07, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        vecs[4]  = '{5'h0A, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0, 1'b0};
        vecs[5]  = '{5'h1F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
        vecs[6]  = '{5'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        vecs[7]  = '{5'h03, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0};
        vecs[8]  = '{5'h04, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0};
        vecs[9]  = '{5'h05, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0};
        vecs[10] = '{5'h02, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[11] = '{5'h08, 32'h00000004, 32'h00000001, 32'h00000010, 1'b0, 1'b0};
        vecs[12] = '{5'h09, 32'h0000001F, 32'h80000000, 32'h00000001, 1'b0, 1'b0};
        vecs[13] = '{5'h0B, 32'h00000000, 32'h0001ABCD, 32'hABCD0000, 1'b0, 1'b0};
        vecs[14] = '{5'h01, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};

        fib[0] = 32'd0;
        fib[1] = 32'd1;
        for (int n = 2; n < 64; n++) fib[n] = fib[n-1] + fib[n-2];
        for (int i = 0; i < 64; i++) model[i] = 32'h0;

        re = 1'b0; we = 1'b0; chain = 1'b0; raddr = '0; waddr = '0;
        wdata_tb = '0; alu_a = '0; alu_b = '0; alu_op = '0;
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        chk_en = 1'b1;

        tick();
        re = 1'b1; raddr = 6'd0;
        #1 check("reset_r0", rdata, 32'h0);

        // Reset clear with no clock edge during the pulse.
        tick();
        we = 1'b1; waddr = 6'd5; wdata_tb = 32'hDEADBEEF;
        tick();
        we = 1'b0; raddr = 6'd5;
        #1 check("r5_written", rdata, 32'hDEADBEEF);
        rst = 1'b1;
        #1 check("r5_during_rst", rdata, 32'h0);
        rst = 1'b0;
        #1 check("r5_after_rst", rdata, 32'h0);

        // Write/read at the top address and read-enable gating.
        tick();
        we = 1'b1; waddr = 6'd63; wdata_tb = 32'h12345678; raddr = 6'd63;
        tick();
        we = 1'b0;
        #1 check("r63_read", rdata, 32'h12345678);
        re = 1'b0;
        #1 check("r63_re_off", rdata, 32'h0);
        re = 1'b1;

        // Read of the address being written: old value until the edge.
        tick();
        we = 1'b1; waddr = 6'd7; wdata_tb = 32'h1;
        tick();
        wdata_tb = 32'h2; raddr = 6'd7;
        #1 check("rdw_before", rdata, 32'h1);
        tick();
        we = 1'b0;
        #1 check("rdw_after", rdata, 32'h2);

        // Fibonacci chain through the ALU into the register file.
        we = 1'b1; waddr = 6'd0; wdata_tb = 32'd0;
        tick();
        waddr = 6'd1; wdata_tb = 32'd1;
        tick();
        chain = 1'b1; alu_op = 5'h01;
        for (int n = 2; n < 64; n++) begin
            alu_a = fib[n-2]; alu_b = fib[n-1]; waddr = 6'(n);
            tick();
        end
        we = 1'b0; chain = 1'b0;
        raddr = 6'd10;
        #1 check("fib_r10", rdata, 32'd55);
        raddr = 6'd47;
        #1 check("fib_r47", rdata, 32'hB11924E1);
        raddr = 6'd48;
        #1 check("fib_r48", rdata, 32'h1E8D0A40);

        // Directed ALU vectors with literal expectations.
        for (int i = 0; i < 15; i++) begin
            tick();
            alu_op = vecs[i].op; alu_a = vecs[i].a; alu_b = vecs[i].b;
            raddr = 6'(i);
            #1;
            check($sformatf("vec%0d_y", i), alu_y, vecs[i].y);
            check($sformatf("vec%0d_zero", i), {31'b0, alu_zero}, {31'b0, vecs[i].z});
            check($sformatf("vec%0d_ovf", i), {31'b0, alu_ovf}, {31'b0, vecs[i].o});
        end

        // Reset overrides a same-cycle write.
        tick();
        raddr = 6'd3;
        #1 check("r3_before", rdata, fib[3]);
        we = 1'b1; waddr = 6'd3; wdata_tb = 32'hAAAA5555; rst = 1'b1;
        tick();
        rst = 1'b0; we = 1'b0;
        #1 check("r3_rst_wins", rdata, 32'h0);
        raddr = 6'd63;
        #1 check("r63_cleared", rdata, 32'h0);

        tick();
        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
